// File: rtl/dec8b10b_lane_if.sv
// Symbol/result bundle for dec8b10b_lane: the slave is the decoder, the master is the
// deserializer/link-layer side that feeds symbols and consumes decoded bytes.
interface dec8b10b_lane_if #(
  parameter int unsigned LANES = 1,
  parameter int unsigned CNT_W = 8
);
  logic                     valid_in;
  logic [LANES*10-1:0]      datin;
  logic                     err_clr;
  logic                     valid_out;
  logic [LANES*8-1:0]       datout;
  logic [LANES-1:0]         kout;
  logic [LANES-1:0]         code_err;
  logic [LANES-1:0]         disp_err;
  logic [LANES-1:0]         rd_out;
  logic [LANES*CNT_W-1:0]   err_cnt;

  modport master (
    output valid_in, datin, err_clr,
    input  valid_out, datout, kout, code_err, disp_err, rd_out, err_cnt
  );

  modport slave (
    input  valid_in, datin, err_clr,
    output valid_out, datout, kout, code_err, disp_err, rd_out, err_cnt
  );
endinterface

// File: rtl/dec8b10b_lane.sv
// Pipelined 10b/8b decoder: LANES independent lanes, 2-cycle latency, per-lane running disparity.
// Define ERR_CNT_EN to build the saturating per-lane error counters (err_cnt/err_clr).
module dec8b10b_lane #(
  parameter int unsigned LANES   = 1,
  parameter int unsigned CNT_W   = 8,
  parameter bit          RD_INIT = 1'b0
) (
  input logic            clk,
  input logic            reset_n,
  dec8b10b_lane_if.slave bus
);

  typedef enum logic [1:0] {DISP_NEUT, DISP_POS, DISP_NEG} disp_e;

  typedef struct packed {
    logic       code_err;
    logic       k;
    logic [7:0] dat;
    disp_e      c6;
    disp_e      c4;
  } cls_t;

  // {valid, EDCBA}; K28 shares the D.28 byte value
  function automatic logic [5:0] dec6(input logic [5:0] s);
    case (s)
      6'b100111, 6'b011000: return {1'b1, 5'd0};
      6'b011101, 6'b100010: return {1'b1, 5'd1};
      6'b101101, 6'b010010: return {1'b1, 5'd2};
      6'b110001:            return {1'b1, 5'd3};
      6'b110101, 6'b001010: return {1'b1, 5'd4};
      6'b101001:            return {1'b1, 5'd5};
      6'b011001:            return {1'b1, 5'd6};
      6'b111000, 6'b000111: return {1'b1, 5'd7};
      6'b111001, 6'b000110: return {1'b1, 5'd8};
      6'b100101:            return {1'b1, 5'd9};
      6'b010101:            return {1'b1, 5'd10};
      6'b110100:            return {1'b1, 5'd11};
      6'b001101:            return {1'b1, 5'd12};
      6'b101100:            return {1'b1, 5'd13};
      6'b011100:            return {1'b1, 5'd14};
      6'b010111, 6'b101000: return {1'b1, 5'd15};
      6'b011011, 6'b100100: return {1'b1, 5'd16};
      6'b100011:            return {1'b1, 5'd17};
      6'b010011:            return {1'b1, 5'd18};
      6'b110010:            return {1'b1, 5'd19};
      6'b001011:            return {1'b1, 5'd20};
      6'b101010:            return {1'b1, 5'd21};
      6'b011010:            return {1'b1, 5'd22};
      6'b111010, 6'b000101: return {1'b1, 5'd23};
      6'b110011, 6'b001100: return {1'b1, 5'd24};
      6'b100110:            return {1'b1, 5'd25};
      6'b010110:            return {1'b1, 5'd26};
      6'b110110, 6'b001001: return {1'b1, 5'd27};
      6'b001110, 6'b001111,
      6'b110000:            return {1'b1, 5'd28};
      6'b101110, 6'b010001: return {1'b1, 5'd29};
      6'b011110, 6'b100001: return {1'b1, 5'd30};
      6'b101011, 6'b010100: return {1'b1, 5'd31};
      default:              return 6'b0;
    endcase
  endfunction

  // {valid, HGF}
  function automatic logic [3:0] dec4(input logic [3:0] f);
    case (f)
      4'b0100, 4'b1011:                   return {1'b1, 3'd0};
      4'b1001:                            return {1'b1, 3'd1};
      4'b0101:                            return {1'b1, 3'd2};
      4'b0011, 4'b1100:                   return {1'b1, 3'd3};
      4'b0010, 4'b1101:                   return {1'b1, 3'd4};
      4'b1010:                            return {1'b1, 3'd5};
      4'b0110:                            return {1'b1, 3'd6};
      4'b0001, 4'b1110, 4'b0111, 4'b1000: return {1'b1, 3'd7};
      default:                            return 4'b0;
    endcase
  endfunction

  function automatic cls_t classify(input logic [9:0] sym);
    logic [5:0] s6;
    logic [3:0] s4;
    logic [3:0] f4;
    logic [5:0] d6;
    logic [3:0] d4;
    logic       k28;
    logic       k_x7;
    logic       a7m;
    logic       a7p;
    logic       bad_a7;
    logic       bad_k28;
    cls_t       c;
    s6   = sym[9:4];
    s4   = sym[3:0];
    k28  = (s6 == 6'b001111) || (s6 == 6'b110000);
    k_x7 = s6 inside {6'b111010, 6'b000101, 6'b110110, 6'b001001,
                      6'b101110, 6'b010001, 6'b011110, 6'b100001};
    a7m  = s6 inside {6'b100011, 6'b010011, 6'b001011};
    a7p  = s6 inside {6'b110100, 6'b101100, 6'b011100};
    // K28 from RD+ is the bitwise complement of its RD- form, so fghj decodes inverted
    f4   = (s6 == 6'b110000) ? ~s4 : s4;
    d6   = dec6(s6);
    d4   = dec4(f4);
    bad_a7  = ((s4 == 4'b0111) && !(a7m || k28 || k_x7)) ||
              ((s4 == 4'b1000) && !(a7p || k28 || k_x7));
    bad_k28 = k28 && !(f4 inside {4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                  4'b0010, 4'b1010, 4'b0110, 4'b1000});
    c.code_err = !d6[5] || !d4[3] || bad_a7 || bad_k28;
    c.k        = k28 || (k_x7 && ((s4 == 4'b0111) || (s4 == 4'b1000)));
    c.dat      = {d4[2:0], d6[4:0]};
    if (($countones(s6) > 3) || (s6 == 6'b111000))      c.c6 = DISP_POS;
    else if (($countones(s6) < 3) || (s6 == 6'b000111)) c.c6 = DISP_NEG;
    else                                                c.c6 = DISP_NEUT;
    if (($countones(s4) > 2) || (s4 == 4'b1100))        c.c4 = DISP_POS;
    else if (($countones(s4) < 2) || (s4 == 4'b0011))   c.c4 = DISP_NEG;
    else                                                c.c4 = DISP_NEUT;
    return c;
  endfunction

  // {illegal_for_rd, rd_next}
  function automatic logic [1:0] rd_step(input disp_e c, input logic rd);
    case (c)
      DISP_POS: return {rd, 1'b1};
      DISP_NEG: return {~rd, 1'b0};
      default:  return {1'b0, rd};
    endcase
  endfunction

  logic                       v1_q, v1_d;
  cls_t [LANES-1:0]           cls_q, cls_d;
  logic                       valid_out_q, valid_out_d;
  logic [LANES-1:0][7:0]      datout_q, datout_d;
  logic [LANES-1:0]           kout_q, kout_d;
  logic [LANES-1:0]           code_err_q, code_err_d;
  logic [LANES-1:0]           disp_err_q, disp_err_d;
  logic [LANES-1:0]           rd_q, rd_d;
  logic [LANES-1:0][1:0]      st6, st4;

  always_comb begin
    v1_d  = bus.valid_in;
    cls_d = cls_q;
    if (bus.valid_in) begin
      for (int unsigned n = 0; n < LANES; n++) begin
        cls_d[n] = classify(bus.datin[10*n +: 10]);
      end
    end
  end

  always_comb begin
    for (int unsigned n = 0; n < LANES; n++) begin
      st6[n] = rd_step(cls_q[n].c6, rd_q[n]);
      st4[n] = rd_step(cls_q[n].c4, st6[n][0]);
    end
  end

  always_comb begin
    valid_out_d = v1_q;
    datout_d    = datout_q;
    kout_d      = kout_q;
    code_err_d  = code_err_q;
    disp_err_d  = disp_err_q;
    rd_d        = rd_q;
    if (v1_q) begin
      for (int unsigned n = 0; n < LANES; n++) begin
        code_err_d[n] = cls_q[n].code_err;
        disp_err_d[n] = st6[n][1] | st4[n][1];
        kout_d[n]     = cls_q[n].k & ~cls_q[n].code_err;
        datout_d[n]   = cls_q[n].code_err ? 8'h00 : cls_q[n].dat;
        rd_d[n]       = st4[n][0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q        <= 1'b0;
      cls_q       <= '0;
      valid_out_q <= 1'b0;
      datout_q    <= '0;
      kout_q      <= '0;
      code_err_q  <= '0;
      disp_err_q  <= '0;
      rd_q        <= {LANES{RD_INIT}};
    end else begin
      v1_q        <= v1_d;
      cls_q       <= cls_d;
      valid_out_q <= valid_out_d;
      datout_q    <= datout_d;
      kout_q      <= kout_d;
      code_err_q  <= code_err_d;
      disp_err_q  <= disp_err_d;
      rd_q        <= rd_d;
    end
  end

  assign bus.valid_out = valid_out_q;
  assign bus.datout    = datout_q;
  assign bus.kout      = kout_q;
  assign bus.code_err  = code_err_q;
  assign bus.disp_err  = disp_err_q;
  assign bus.rd_out    = rd_q;

`ifdef ERR_CNT_EN
  logic [LANES-1:0][CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    for (int unsigned n = 0; n < LANES; n++) begin
      if (bus.err_clr) begin
        err_cnt_d[n] = '0;
      end else if (v1_q && (cls_q[n].code_err | st6[n][1] | st4[n][1]) &&
                   (err_cnt_q[n] != '1)) begin
        err_cnt_d[n] = err_cnt_q[n] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.err_cnt    = '0;
`endif

endmodule

// File: doc/dec8b10b_lane.md
Name: dec8b10b_lane

Overview:
- Parametrised, pipelined 10b/8b decoder and successor to the fixed 3b/4b sub-block decoder.
- Decodes LANES independent 10-bit symbols per cycle into bytes plus K flags.
- Tracks running disparity (RD) per lane and flags code and disparity errors.
- Sits between the deserializer/aligner and the link layer.

Parameters:
- LANES, 1, number of parallel independent lanes.
- CNT_W, 8, width of each per-lane error counter (used only with ERR_CNT_EN).
- RD_INIT, 0, reset running disparity: 0 = RD-, 1 = RD+.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  datin holds symbols this cycle.
- datin  in  LANES*10  lane n at [10n+9:10n]; bit order {a,b,c,d,e,i,f,g,h,j}, a at MSB.
- valid_out  out  1  outputs below are valid.
- datout  out  LANES*8  lane n at [8n+7:8n]; {H,G,F,E,D,C,B,A}.
- kout  out  LANES  control symbol decoded.
- code_err  out  LANES  symbol not in 8b/10b code table.
- disp_err  out  LANES  symbol illegal for current RD.
- rd_out  out  LANES  RD after this symbol (1 = RD+).
- err_clr  in  1  synchronous clear of error counters (ERR_CNT_EN only).
- err_cnt  out  LANES*CNT_W  per-lane error counts (ERR_CNT_EN only).

Behaviour:
- Reset: valid_out, datout, kout, code_err, disp_err = 0; rd_out and internal RD = RD_INIT; err_cnt = 0. Reset mid-stream discards all in-flight symbols.
- Pipeline: fixed latency of 2 clk. valid_out(t+2) = valid_in(t), no bubbles, no backpressure.
  - Stage 1 registers the 6b/4b classifications.
  - Stage 2 applies RD, decodes and registers outputs.
- Outputs are held when valid_out = 0. RD advances only on valid symbols.
- 6b sub-block abcdei decodes to EDCBA per the standard 5b/6b table. 4b sub-block fghj decodes to HGF per the 3b/4b table, both alternates accepted:
  - 0100/1011 -> 000; 1001 -> 001; 0101 -> 010; 0011/1100 -> 011
  - 0010/1101 -> 100; 1010 -> 101; 0110 -> 110
  - 0001/1110 and A7 0111/1000 -> 111
- Code validity. code_err = 1 when any of:
  - 6b has fewer than 2 or more than 4 ones, or is not in the table;
  - 4b has 0 or 4 ones;
  - 0111 appears other than after D.17/D.18/D.20 (RD-) or a K code;
  - 1000 appears other than after D.11/D.13/D.14 (RD+) or a K code;
  - 001111/110000 appear with a fghj not valid for K28.
- On code_err: datout = 0x00, kout = 0, disp_err is still evaluated.
- K symbols: K28.0–K28.7 (abcdei 001111/110000) and K23.7, K27.7, K29.7, K30.7 (6b + fghj 1000/0111). kout = 1, datout = the K byte (e.g. K28.5 -> 0xBC).
- RD rules, applied to the 6b sub-block and then to the 4b sub-block using the intermediate RD:
  - Unbalanced sub-block: +2 is legal only at RD-, -2 only at RD+. It flips RD to its sign.
  - Balanced 111000/1100 are legal only at RD- and set RD+.
  - Balanced 000111/0011 are legal only at RD+ and set RD-.
  - Other balanced sub-blocks leave RD unchanged.
  - disp_err = 1 if either sub-block is illegal for its RD.
- RD update always follows the received bits, even on error (self-resync). rd_out = final RD.
- Lanes are fully independent: separate RD, errors and counters.

Optional Feature:
- Macro: ERR_CNT_EN.
- Defined:
  - Per lane, err_cnt increments by 1 on each valid symbol with code_err | disp_err.
  - Counts saturate at 2^CNT_W-1 (no wrap).
  - err_clr has priority over a same-cycle increment (counter becomes 0).
- Undefined: err_clr is ignored, err_cnt is tied to 0, and no counter flops exist.

Test Plan:
- RD-, single valid symbol 1001110100 (D.0.0) -> 2 clk later: datout = 0x00, kout = 0, code_err = 0, disp_err = 0, rd_out = 0.
- Alternating K28.5 0011111010 then 1100000101, starting RD- -> kout = 1, datout = 0xBC each, rd_out toggles 1, 0, no errors.
- RD-, two consecutive 0011111010 -> second has disp_err = 1, code_err = 0, datout = 0xBC; rd_out stays 1.
- 1111110000 -> code_err = 1, datout = 0x00, kout = 0. With ERR_CNT_EN, err_cnt += 1; 300 errors with CNT_W = 8 -> err_cnt = 255; err_clr -> 0.
- LANES = 4: different symbol per lane plus a disparity error on lane 2 only -> only disp_err[2] = 1, other lanes decode correctly.
- reset_n low while valid_in is streaming -> all outputs 0 and rd_out = RD_INIT immediately. First symbol after release appears 2 clk after its valid_in.
